// File: rtl/msp_sr_pkg.sv
// Shared definitions for the MSP430 status register (R2/SR) and its low-power sequencer.
package msp_sr_pkg;

  localparam int unsigned SR_C      = 0;
  localparam int unsigned SR_Z      = 1;
  localparam int unsigned SR_N      = 2;
  localparam int unsigned SR_GIE    = 3;
  localparam int unsigned SR_CPUOFF = 4;
  localparam int unsigned SR_OSCOFF = 5;
  localparam int unsigned SR_SCG0   = 6;
  localparam int unsigned SR_SCG1   = 7;
  localparam int unsigned SR_V      = 8;

  localparam logic [15:0] SR_IMPL_MASK = 16'h01FF;
  localparam logic [15:0] SR_IRQ_KEEP  = 16'h0040;

  typedef enum logic [1:0] {
    LPM_ACTIVE = 2'd0,
    LPM_SLEEP  = 2'd1,
    LPM_WAKE   = 2'd2
  } lpm_state_e;

endpackage

// File: rtl/lpm_wake_fsm.sv
// Low-power-mode sequencer: ACTIVE/SLEEP/WAKE state and wake-up delay counter.
module lpm_wake_fsm
  import msp_sr_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpuoff,
  input  logic       accept,
  output logic [1:0] state,
  output logic       cpu_stall
);

  localparam logic [3:0] WAKE_INIT = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

  lpm_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LPM_ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LPM_ACTIVE: begin
        if (cpuoff && !accept) state_d = LPM_SLEEP;
      end
      LPM_SLEEP: begin
        if (accept) begin
          if (WAKE_CYCLES == 0) begin
            state_d = LPM_ACTIVE;
          end else begin
            state_d = LPM_WAKE;
            cnt_d   = WAKE_INIT;
          end
        end
      end
      LPM_WAKE: begin
        if (cnt_q == 4'd0) state_d = LPM_ACTIVE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = LPM_ACTIVE;
    endcase
  end

  assign state     = state_q;
  assign cpu_stall = (state_q != LPM_ACTIVE);

endmodule

// File: rtl/sr_reg.sv
// MSP430 status register R2/SR with interrupt acceptance and low-power sequencing.
// Optional macro SR_NMI_EN adds the nmi_req port to the accept condition.
module sr_reg
  import msp_sr_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 4,
  parameter logic [15:0] SR_RESET    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] reg_SR_in,
  input  logic        sr_we,
  input  logic        instr_bound,
  input  logic        irq_req,
`ifdef SR_NMI_EN
  input  logic        nmi_req,
`endif
  output logic [15:0] reg_SR_out,
  output logic [15:0] sr_saved,
  output logic        irq_ack,
  output logic        cpu_stall
);

  logic [15:0] sr_q;
  logic [15:0] saved_q;
  logic        ack_q;
  logic [1:0]  lpm_state;
  logic        irq_pending;
  logic        accept;

`ifdef SR_NMI_EN
  assign irq_pending = (irq_req & sr_q[SR_GIE]) | nmi_req;
`else
  assign irq_pending = irq_req & sr_q[SR_GIE];
`endif

  // Boundary-qualified while running, unconditional while asleep, blocked during wake-up.
  assign accept = irq_pending &
                  (((lpm_state == LPM_ACTIVE) & instr_bound) | (lpm_state == LPM_SLEEP));

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= SR_RESET & SR_IMPL_MASK;
      saved_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        saved_q <= sr_q;
        sr_q    <= sr_q & SR_IRQ_KEEP;
      end else if (sr_we) begin
        sr_q <= reg_SR_in & SR_IMPL_MASK;
      end
    end
  end

  lpm_wake_fsm #(
    .WAKE_CYCLES(WAKE_CYCLES)
  ) u_lpm (
    .clk      (clk),
    .rst      (rst),
    .cpuoff   (sr_q[SR_CPUOFF]),
    .accept   (accept),
    .state    (lpm_state),
    .cpu_stall(cpu_stall)
  );

  assign reg_SR_out = sr_q;
  assign sr_saved   = saved_q;
  assign irq_ack    = ack_q;

endmodule

// File: doc/sr_reg.md
Name: sr_reg

Overview:
- Architectural status register (R2/SR) of the MSP430 core.
- Latches the 16-bit value chosen by the SR input select stage, and drives reg_SR_out back to that select stage, the datapath and the decoder.
- Also owns interrupt acceptance, which clears the SR and pulses an acknowledge.
- Also owns the low-power-mode sequencer, which stalls the CPU while CPUOFF is set and runs a wake-up delay.

Parameters:
- WAKE_CYCLES, 4, stall cycles between interrupt acceptance in sleep and CPU resume; legal range 0..15.
- SR_RESET, 16'h0000, value loaded into SR on reset; bits 15:9 must be 0.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_SR_in  input  16  next SR value from SR input select.
- sr_we  input  1  write reg_SR_in into SR this edge.
- instr_bound  input  1  current cycle is an instruction boundary; interrupts are accepted only here while ACTIVE.
- irq_req  input  1  level, maskable interrupt pending.
- nmi_req  input  1  level, non-maskable interrupt pending (see Optional Feature).
- reg_SR_out  output  16  current SR.
- sr_saved  output  16  SR value captured at interrupt acceptance, for stacking.
- irq_ack  output  1  one-cycle pulse, interrupt accepted.
- cpu_stall  output  1  high while state is not ACTIVE.

Behaviour:
- Bit map:
  - C = 0, Z = 1, N = 2, GIE = 3, CPUOFF = 4, OSCOFF = 5, SCG0 = 6, SCG1 = 7, V = 8.
  - Bits 15:9 are reserved and always read 0.
- Reset (rst = 1 at an edge):
  - reg_SR_out = SR_RESET & 16'h01FF, sr_saved = 0, irq_ack = 0, cpu_stall = 0.
  - state = ACTIVE, wake counter = 0.
  - Reset overrides everything, including mid-wake or mid-sleep.
- Write: when sr_we = 1, reg_SR_out <= reg_SR_in & 16'h01FF at the next edge, so the new value is visible 1 cycle later.
- accept condition: (irq_req & GIE) | nmi_req.
  - In ACTIVE it is further qualified by instr_bound.
  - In SLEEP no qualification is applied.
  - In WAKE nothing is accepted.
- On accept at edge t:
  - sr_saved <= reg_SR_out.
  - reg_SR_out <= reg_SR_out & 16'h0040 (only SCG0 retained).
  - irq_ack = 1 during cycle t+1 only.
- Simultaneous accept and sr_we: the accept wins and sr_we is dropped. The decoder must not assert sr_we on an accepted boundary.
- FSM states (registered): ACTIVE = 2'd0, SLEEP = 2'd1, WAKE = 2'd2. Transitions:
  - ACTIVE -> SLEEP when reg_SR_out[CPUOFF] = 1 and no accept this cycle. cpu_stall rises the cycle after CPUOFF becomes visible.
  - SLEEP -> WAKE on accept; counter <= WAKE_CYCLES - 1.
  - SLEEP -> ACTIVE directly on accept if WAKE_CYCLES = 0.
  - WAKE: counter decrements each cycle; at counter == 0 -> ACTIVE.
  - Stall duration from accept edge to cpu_stall = 0 is exactly WAKE_CYCLES cycles.
- A write during SLEEP/WAKE (e.g. from a debug port) updates SR but does not change state.
- RETI is the decoder asserting sr_we with the popped value. If the popped CPUOFF = 1, the next cycle returns to SLEEP.
- Counter is 4 bits and never wraps below 0.
- Illegal state 2'd3 goes to ACTIVE.

Optional Feature:
- Macro: SR_NMI_EN.
- Defined: nmi_req port exists and participates in the accept condition; GIE is ignored for it.
- Undefined:
  - No nmi_req port; the accept condition uses irq_req & GIE only.
  - All other behaviour is identical.

Decomposition:
- Shared package/include msp_sr_pkg holds:
  - Bit index constants SR_C, SR_Z, SR_N, SR_GIE, SR_CPUOFF, SR_OSCOFF, SR_SCG0, SR_SCG1, SR_V.
  - SR_IMPL_MASK = 16'h01FF and SR_IRQ_KEEP = 16'h0040.
  - LPM state encodings.
- One natural sub-module, lpm_wake_fsm. It holds the state register and wake counter, takes cpuoff and accept, and outputs state/cpu_stall.
- The SR register and accept logic stay in sr_reg.

Test Plan:
- Reset check: rst with SR_RESET = 16'h0000; then write sr_we with reg_SR_in = 16'hFFFF -> reg_SR_out = 16'h01FF next cycle, cpu_stall = 0.
- Masked interrupt:
  - SR = 16'h0008 (GIE), irq_req = 1, instr_bound = 1 -> next cycle irq_ack = 1, sr_saved = 16'h0008, reg_SR_out = 16'h0000.
  - With GIE = 0 -> no ack.
- Low-power entry and wake-up:
  - Write 16'h0058 (GIE | CPUOFF | SCG0) -> cpu_stall = 1 the cycle after SR update.
  - irq_req = 1 -> ack, SR = 16'h0040, cpu_stall stays 1 for exactly 4 cycles with WAKE_CYCLES = 4, then 0.
  - Repeat with WAKE_CYCLES = 0 -> stall drops on the ack cycle.
- RETI: after wake-up, sr_we with 16'h0018 -> SLEEP re-entered, cpu_stall = 1.
- Collision and reset: accept and sr_we in the same cycle -> SR cleared, written value lost; rst asserted in WAKE -> all outputs at reset values the next cycle, state ACTIVE.
- Non-maskable interrupt (SR_NMI_EN builds): GIE = 0, nmi_req = 1 at instr_bound -> irq_ack = 1.
